ldst_mem_stage: RTL and testbench
=================================

// Module: ldst_mem_stage
// PURPOSE
//  Memory-access stage placed directly downstream of the CPU execute stage.
//  - Accepts one load/store request per transaction: computed address, store data, funct3, rd.
//  - Drives the shared read/write memory port (o_ldst_*) with word-aligned address, byte
//    enables and lane-replicated store data.
//  - Extracts and sign/zero-extends load data, returning it as a register-file writeback.
// PARAMETERS
//  IW     32  data/address width (bits); byte-lane logic is fixed at IW=32
//  RW     5   register index width
// PORTS
//  clk                 in   1   clock
//  reset               in   1   reset, synchronous, active-high
//  i_req_valid         in   1   request from execute stage is valid
//  o_req_ready         out  1   stage can accept a request this cycle
//  i_req_load          in   1   1 = load, 0 = store
//  i_req_funct3        in   3   RV32I funct3 of the load/store
//  i_req_addr          in   IW  effective byte address (rs1 + imm)
//  i_req_wrdata        in   IW  store source value (rs2)
//  i_req_rd            in   RW  load destination register
//  o_ldst_addr         out  IW  word-aligned memory address {addr[31:2],2'b00}
//  o_ldst_rd           out  1   memory read strobe
//  o_ldst_wr           out  1   memory write strobe
//  o_ldst_byte_en      out  4   byte-lane enables
//  o_ldst_wrdata       out  IW  lane-replicated store data
//  i_ldst_rddata       in   IW  read data, valid the cycle after the read is accepted
//  i_ldst_waitrequest  in   1   memory stall; strobe is held while high
//  o_wb_valid          out  1   writeback pulse, 1 cycle
//  o_wb_rd             out  RW  writeback destination
//  o_wb_data           out  IW  extended load data
//  o_fault             out  1   1-cycle pulse: misaligned access or illegal funct3
// BEHAVIOUR
//  - FSM states: IDLE, ISSUE, RDWAIT, WB. All outputs are decoded from registered state.
//  - Reset edge: state=IDLE; o_ldst_rd/wr=0, byte_en=0, addr=0, wrdata=0, wb_valid=0,
//    wb_rd=0, wb_data=0, fault=0.
//  - o_req_ready=1 only in IDLE with reset low. A transfer happens when valid & ready.
//  - Reset mid-transaction abandons it: strobes are 0 after the reset edge, and no writeback
//    or fault is produced.
//  - IDLE + transfer: latch the request.
//    - Fault conditions: half access with addr[0]=1; word access with addr[1:0]!=0;
//      load funct3 not in {0,1,2,4,5}; store funct3 not in {0,1,2}.
//    - On fault: o_fault=1 next cycle, no memory access, stay IDLE.
//    - Otherwise go to ISSUE.
//  - ISSUE: assert o_ldst_rd (load) or o_ldst_wr (store). Addr, byte_en and wrdata stay
//    stable while i_ldst_waitrequest=1.
//    - Waitrequest low, store: complete and return to IDLE.
//    - Waitrequest low, load: go to RDWAIT.
//  - RDWAIT: capture i_ldst_rddata, then go to WB.
//  - WB: o_wb_valid=1 for one cycle (forced 0 when rd==0), then return to IDLE.
//  - Latency with no stalls: load accepted at T -> strobe at T+1 -> o_wb_valid at T+3.
//    Store accepted at T -> o_ldst_wr at T+1. Each waitrequest cycle adds one cycle.
//  - Byte enables by access size (a = addr[1:0]):
//    - byte: 4'b0001 << a
//    - half: 4'b0011 << {a[1],1'b0}
//    - word: 4'b1111
//  - Store data: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
//  - Load extract: lane = rddata >> (8*a).
//    - LB: sign-extend lane[7:0]; LBU: zero-extend lane[7:0].
//    - LH: sign-extend lane[15:0]; LHU: zero-extend lane[15:0].
//    - LW: rddata unchanged.
//  - One transaction in flight; no request is accepted outside IDLE.
// TESTING
//  - LW addr=0x100, rd=5, mem[0x100]=0xDEADBEEF -> addr=0x100, byte_en=1111,
//    wb_rd=5, wb_data=0xDEADBEEF at T+3.
//  - LB addr=0x103, word=0x80FF_FF7F -> byte_en=1000, wb_data=0xFFFFFF80.
//    Same access with LBU -> wb_data=0x00000080.
//  - SH addr=0x22, rs2=0x1234ABCD -> o_ldst_wr=1, addr=0x20, byte_en=1100,
//    wrdata=0xABCDABCD; no o_wb_valid.
//  - LW addr=0x102 -> o_fault pulse; no strobe; ready=1 next cycle.
//    Store funct3=3 -> o_fault pulse.
//  - waitrequest held high 3 cycles during LH addr=0x10 -> strobe/addr/byte_en stable
//    4 cycles; wb at T+6.
//  - Reset asserted in RDWAIT -> no wb_valid; IDLE/ready=1 after reset deasserts;
//    LW rd=0 -> wb_valid stays 0.

Source files
------------

// File: rtl/ldst_mem_stage_if.sv
// Request, memory-port and writeback signals of the load/store memory stage.
interface ldst_mem_stage_if #(
  parameter int unsigned IW = 32,
  parameter int unsigned RW = 5
) ();
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_load;
  logic [2:0]    i_req_funct3;
  logic [IW-1:0] i_req_addr;
  logic [IW-1:0] i_req_wrdata;
  logic [RW-1:0] i_req_rd;

  logic [IW-1:0] o_ldst_addr;
  logic          o_ldst_rd;
  logic          o_ldst_wr;
  logic [3:0]    o_ldst_byte_en;
  logic [IW-1:0] o_ldst_wrdata;
  logic [IW-1:0] i_ldst_rddata;
  logic          i_ldst_waitrequest;

  logic          o_wb_valid;
  logic [RW-1:0] o_wb_rd;
  logic [IW-1:0] o_wb_data;
  logic          o_fault;

  // The stage itself.
  modport slave (
    input  i_req_valid, i_req_load, i_req_funct3, i_req_addr, i_req_wrdata, i_req_rd,
    input  i_ldst_rddata, i_ldst_waitrequest,
    output o_req_ready, o_ldst_addr, o_ldst_rd, o_ldst_wr, o_ldst_byte_en, o_ldst_wrdata,
    output o_wb_valid, o_wb_rd, o_wb_data, o_fault
  );

  // Execute stage plus memory plus register file, seen as one environment.
  modport master (
    output i_req_valid, i_req_load, i_req_funct3, i_req_addr, i_req_wrdata, i_req_rd,
    output i_ldst_rddata, i_ldst_waitrequest,
    input  o_req_ready, o_ldst_addr, o_ldst_rd, o_ldst_wr, o_ldst_byte_en, o_ldst_wrdata,
    input  o_wb_valid, o_wb_rd, o_wb_data, o_fault
  );
endinterface

// File: rtl/ldst_mem_stage.sv
// Load/store memory-access stage: issues one aligned access to the shared memory port and
// returns extended load data as a register-file writeback. One transaction in flight.
module ldst_mem_stage #(
  parameter int unsigned IW = 32,
  parameter int unsigned RW = 5
) (
  input  logic       clk,
  input  logic       reset,
  ldst_mem_stage_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StRdwait, StWb} state_e;

  state_e        state_q, state_d;
  logic          load_q, load_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    offs_q, offs_d;
  logic [RW-1:0] rd_q, rd_d;

  logic [IW-1:0] ldst_addr_q, ldst_addr_d;
  logic          ldst_rd_q, ldst_rd_d;
  logic          ldst_wr_q, ldst_wr_d;
  logic [3:0]    byte_en_q, byte_en_d;
  logic [IW-1:0] wrdata_q, wrdata_d;
  logic          wb_valid_q, wb_valid_d;
  logic [RW-1:0] wb_rd_q, wb_rd_d;
  logic [IW-1:0] wb_data_q, wb_data_d;
  logic          fault_q, fault_d;

  logic          req_fault;
  logic [3:0]    req_be;
  logic [IW-1:0] req_wd;
  logic [IW-1:0] ld_lane;
  logic [IW-1:0] ld_ext;

  // Decode the incoming request: legality, alignment, lane enables and replicated data.
  always_comb begin
    req_fault = 1'b0;
    req_be    = 4'b1111;
    req_wd    = bus.i_req_wrdata;
    unique case (bus.i_req_funct3[1:0])
      2'd0: begin
        req_be = 4'b0001 << bus.i_req_addr[1:0];
        req_wd = {4{bus.i_req_wrdata[7:0]}};
      end
      2'd1: begin
        req_be    = 4'b0011 << {bus.i_req_addr[1], 1'b0};
        req_wd    = {2{bus.i_req_wrdata[15:0]}};
        req_fault = bus.i_req_addr[0];
      end
      2'd2: begin
        req_fault = (bus.i_req_addr[1:0] != 2'b00);
      end
      default: begin
        req_fault = 1'b1;
      end
    endcase
    // Loads allow the unsigned byte/half variants only; stores have no funct3[2] encodings.
    if (bus.i_req_funct3[2] && (!bus.i_req_load || bus.i_req_funct3[1])) begin
      req_fault = 1'b1;
    end
  end

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    ld_lane = bus.i_ldst_rddata >> {offs_q, 3'b000};
    unique case (funct3_q)
      3'd0:    ld_ext = {{24{ld_lane[7]}}, ld_lane[7:0]};
      3'd1:    ld_ext = {{16{ld_lane[15]}}, ld_lane[15:0]};
      3'd4:    ld_ext = {24'd0, ld_lane[7:0]};
      3'd5:    ld_ext = {16'd0, ld_lane[15:0]};
      default: ld_ext = bus.i_ldst_rddata;
    endcase
  end

  // Next-state and registered-output logic of the transaction FSM.
  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    funct3_d    = funct3_q;
    offs_d      = offs_q;
    rd_d        = rd_q;
    ldst_addr_d = ldst_addr_q;
    ldst_rd_d   = ldst_rd_q;
    ldst_wr_d   = ldst_wr_q;
    byte_en_d   = byte_en_q;
    wrdata_d    = wrdata_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    fault_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_req_valid) begin
          load_d   = bus.i_req_load;
          funct3_d = bus.i_req_funct3;
          offs_d   = bus.i_req_addr[1:0];
          rd_d     = bus.i_req_rd;
          if (req_fault) begin
            fault_d = 1'b1;
          end else begin
            state_d     = StIssue;
            ldst_addr_d = {bus.i_req_addr[IW-1:2], 2'b00};
            ldst_rd_d   = bus.i_req_load;
            ldst_wr_d   = !bus.i_req_load;
            byte_en_d   = req_be;
            wrdata_d    = req_wd;
          end
        end
      end
      StIssue: begin
        if (!bus.i_ldst_waitrequest) begin
          ldst_rd_d = 1'b0;
          ldst_wr_d = 1'b0;
          state_d   = load_q ? StRdwait : StIdle;
        end
      end
      StRdwait: begin
        wb_valid_d = (rd_q != '0);
        wb_rd_d    = rd_q;
        wb_data_d  = ld_ext;
        state_d    = StWb;
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      load_q      <= 1'b0;
      funct3_q    <= 3'd0;
      offs_q      <= 2'd0;
      rd_q        <= '0;
      ldst_addr_q <= '0;
      ldst_rd_q   <= 1'b0;
      ldst_wr_q   <= 1'b0;
      byte_en_q   <= 4'd0;
      wrdata_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      funct3_q    <= funct3_d;
      offs_q      <= offs_d;
      rd_q        <= rd_d;
      ldst_addr_q <= ldst_addr_d;
      ldst_rd_q   <= ldst_rd_d;
      ldst_wr_q   <= ldst_wr_d;
      byte_en_q   <= byte_en_d;
      wrdata_q    <= wrdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.o_req_ready    = (state_q == StIdle) && !reset;
  assign bus.o_ldst_addr    = ldst_addr_q;
  assign bus.o_ldst_rd      = ldst_rd_q;
  assign bus.o_ldst_wr      = ldst_wr_q;
  assign bus.o_ldst_byte_en = byte_en_q;
  assign bus.o_ldst_wrdata  = wrdata_q;
  assign bus.o_wb_valid     = wb_valid_q;
  assign bus.o_wb_rd        = wb_rd_q;
  assign bus.o_wb_data      = wb_data_q;
  assign bus.o_fault        = fault_q;

endmodule

// File: tb/tb_ldst_mem_stage.sv
// Bench for ldst_mem_stage: directed vector table, reset-abandon sequence and randomized
// transactions checked against a byte-level reference model.
module tb_ldst_mem_stage;

  logic clk;
  logic reset;
  logic [31:0] cur_word;
  int n_pass;
  int n_total;

  ldst_mem_stage_if #(.IW(32), .RW(5)) bus ();

  ldst_mem_stage #(.IW(32), .RW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: read data appears the cycle after an accepted read, noise otherwise.
  always @(posedge clk) begin
    if (bus.o_ldst_rd && !bus.i_ldst_waitrequest) bus.i_ldst_rddata <= cur_word;
    else bus.i_ldst_rddata <= $urandom;
  end

  typedef struct {
    bit          load;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] word;
    logic [4:0]  rd;
    int          stall;
    bit          e_fault;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_wb;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model working from access size in bytes and byte offset.
  function automatic void model(input bit load, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] word,
                                output bit flt, output logic [3:0] be,
                                output logic [31:0] wdat, output logic [31:0] ld);
    int size;
    int off;
    longint v;
    longint mask;
    bit illegal;
    logic [1:0] sz_code;
    sz_code = f3[1:0];
    size = 1 << sz_code;
    off = int'(addr % 4);
    illegal = load ? (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) : (f3 > 3'd2);
    flt = illegal || ((addr % size) != 0);
    be = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) wdat[8*i +: 8] = wd[8*(i % size) +: 8];
    v = longint'(word) >> (8 * off);
    if (size < 4) begin
      mask = (longint'(1) << (8 * size)) - 1;
      v = v & mask;
      if (!f3[2] && v[8*size-1]) v = v | ~mask;
    end
    ld = v[31:0];
  endfunction

  // Apply one request and check every cycle up to and including its writeback.
  task automatic do_txn(input vec_t t);
    chk("ready_before", 32'(bus.o_req_ready), 32'd1);
    cur_word             = t.word;
    bus.i_req_valid      = 1'b1;
    bus.i_req_load       = t.load;
    bus.i_req_funct3     = t.f3;
    bus.i_req_addr       = t.addr;
    bus.i_req_wrdata     = t.wd;
    bus.i_req_rd         = t.rd;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    if (t.e_fault) begin
      chk("fault_pulse", 32'(bus.o_fault), 32'd1);
      chk("fault_no_strobe", 32'({bus.o_ldst_rd, bus.o_ldst_wr}), 32'd0);
      chk("fault_ready", 32'(bus.o_req_ready), 32'd1);
      @(negedge clk);
      chk("fault_clear", 32'(bus.o_fault), 32'd0);
      return;
    end
    chk("no_fault", 32'(bus.o_fault), 32'd0);
    for (int k = 0; k <= t.stall; k++) begin
      chk("strobe_rd", 32'(bus.o_ldst_rd), 32'(t.load));
      chk("strobe_wr", 32'(bus.o_ldst_wr), 32'(!t.load));
      chk("ldst_addr", bus.o_ldst_addr, t.addr & ~32'd3);
      chk("byte_en", 32'(bus.o_ldst_byte_en), 32'(t.e_be));
      if (!t.load) chk("wrdata", bus.o_ldst_wrdata, t.e_wd);
      chk("busy_not_ready", 32'(bus.o_req_ready), 32'd0);
      bus.i_ldst_waitrequest = (k < t.stall);
      @(negedge clk);
    end
    chk("strobe_drop", 32'({bus.o_ldst_rd, bus.o_ldst_wr}), 32'd0);
    chk("no_early_wb", 32'(bus.o_wb_valid), 32'd0);
    if (!t.load) begin
      chk("store_ready", 32'(bus.o_req_ready), 32'd1);
      return;
    end
    @(negedge clk);
    chk("wb_valid", 32'(bus.o_wb_valid), 32'(t.rd != 5'd0));
    chk("wb_rd", 32'(bus.o_wb_rd), 32'(t.rd));
    chk("wb_data", bus.o_wb_data, t.e_wb);
    @(negedge clk);
    chk("wb_pulse_end", 32'(bus.o_wb_valid), 32'd0);
    chk("ready_after", 32'(bus.o_req_ready), 32'd1);
  endtask

  vec_t vecs[$];
  vec_t t;

  initial begin
    n_pass = 0;
    n_total = 0;
    cur_word = 32'd0;
    bus.i_req_valid = 1'b0;
    bus.i_req_load = 1'b0;
    bus.i_req_funct3 = 3'd0;
    bus.i_req_addr = 32'd0;
    bus.i_req_wrdata = 32'd0;
    bus.i_req_rd = 5'd0;
    bus.i_ldst_waitrequest = 1'b0;
    reset = 1'b1;

    //           load f3    addr          wd            word          rd    st flt be       wd            wb
    vecs.push_back('{1, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 5'd5, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1, 3'd0, 32'h103, 32'h0,        32'h80FFFF7F, 5'd7, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80});
    vecs.push_back('{1, 3'd4, 32'h103, 32'h0,        32'h80FFFF7F, 5'd7, 0, 0, 4'b1000, 32'h0,        32'h00000080});
    vecs.push_back('{0, 3'd1, 32'h22,  32'h1234ABCD, 32'h0,        5'd3, 0, 0, 4'b1100, 32'hABCDABCD, 32'h0});
    vecs.push_back('{1, 3'd2, 32'h102, 32'h0,        32'h0,        5'd4, 0, 1, 4'b0000, 32'h0,        32'h0});
    vecs.push_back('{0, 3'd3, 32'h40,  32'h0,        32'h0,        5'd4, 0, 1, 4'b0000, 32'h0,        32'h0});
    vecs.push_back('{1, 3'd1, 32'h10,  32'h0,        32'h12348001, 5'd9, 3, 0, 4'b0011, 32'h0,        32'hFFFF8001});
    vecs.push_back('{1, 3'd5, 32'h12,  32'h0,        32'h87654321, 5'd2, 1, 0, 4'b1100, 32'h0,        32'h00008765});
    vecs.push_back('{0, 3'd0, 32'h5,   32'h000000EE, 32'h0,        5'd1, 2, 0, 4'b0010, 32'hEEEEEEEE, 32'h0});
    vecs.push_back('{0, 3'd2, 32'h44,  32'h01020304, 32'h0,        5'd1, 0, 0, 4'b1111, 32'h01020304, 32'h0});
    vecs.push_back('{1, 3'd6, 32'h48,  32'h0,        32'h0,        5'd1, 0, 1, 4'b0000, 32'h0,        32'h0});
    vecs.push_back('{1, 3'd1, 32'h31,  32'h0,        32'h0,        5'd1, 0, 1, 4'b0000, 32'h0,        32'h0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.o_req_ready), 32'd0);
    chk("rst_strobes", 32'({bus.o_ldst_rd, bus.o_ldst_wr}), 32'd0);
    chk("rst_addr", bus.o_ldst_addr, 32'd0);
    chk("rst_be", 32'(bus.o_ldst_byte_en), 32'd0);
    chk("rst_wrdata", bus.o_ldst_wrdata, 32'd0);
    chk("rst_wb", 32'({bus.o_wb_valid, bus.o_wb_rd}), 32'd0);
    chk("rst_wb_data", bus.o_wb_data, 32'd0);
    chk("rst_fault", 32'(bus.o_fault), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) do_txn(vecs[i]);

    // Reset while the read is outstanding abandons the load.
    cur_word = 32'h55AA55AA;
    bus.i_req_valid = 1'b1;
    bus.i_req_load = 1'b1;
    bus.i_req_funct3 = 3'd2;
    bus.i_req_addr = 32'h80;
    bus.i_req_rd = 5'd6;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rrst_strobes", 32'({bus.o_ldst_rd, bus.o_ldst_wr}), 32'd0);
    chk("rrst_wb", 32'(bus.o_wb_valid), 32'd0);
    chk("rrst_fault", 32'(bus.o_fault), 32'd0);
    chk("rrst_not_ready", 32'(bus.o_req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rrst_ready", 32'(bus.o_req_ready), 32'd1);
    chk("rrst_wb2", 32'(bus.o_wb_valid), 32'd0);
    @(negedge clk);
    chk("rrst_wb3", 32'(bus.o_wb_valid), 32'd0);

    t = '{1, 3'd2, 32'h200, 32'h0, 32'hCAFEF00D, 5'd0, 0, 0, 4'b1111, 32'h0, 32'hCAFEF00D};
    do_txn(t);

    for (int n = 0; n < 300; n++) begin
      int r;
      logic [31:0] a;
      t.load = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) t.f3 = 3'($urandom_range(0, 7));
      else if (t.load) begin
        r = $urandom_range(0, 4);
        t.f3 = (r > 2) ? 3'(r + 1) : 3'(r);
      end else t.f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      r = $urandom_range(0, 3);
      if (r == 1) a[0] = 1'b0;
      else if (r >= 2) a[1:0] = 2'b00;
      t.addr  = a;
      t.wd    = $urandom;
      t.word  = $urandom;
      t.rd    = 5'($urandom_range(0, 31));
      t.stall = $urandom_range(0, 2);
      model(t.load, t.f3, t.addr, t.wd, t.word, t.e_fault, t.e_be, t.e_wd, t.e_wb);
      do_txn(t);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
